// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a non-forwarding 5-stage RV32I pipeline.
// A destination scoreboard detects RAW hazards at decode; a two-state FSM freezes on slow memory.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] id_instr_i,
    input  logic        br_taken_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        pc_en_o,
    output logic        if_id_en_o,
    output logic        id_ex_en_o,
    output logic        ex_me_en_o,
    output logic        me_wb_en_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        mem_err_o,
    output logic [31:0] stall_cnt_o
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned REG_W = 5;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    typedef enum logic {S_RUN, S_MEM_WAIT} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ex_v_q, ex_v_d, me_v_q, me_v_d, wb_v_q, wb_v_d;
    logic [REG_W-1:0]   ex_rd_q, ex_rd_d, me_rd_q, me_rd_d, wb_rd_q, wb_rd_d;
    logic               mem_err_q, mem_err_d;
    logic [31:0]        stall_cnt_q, stall_cnt_d;

    logic [6:0]         opcode;
    logic [REG_W-1:0]   rs1, rs2, rd;
    logic               rs1_used, rs2_used, rd_written;
    logic               hazard, freeze;
    logic               unused_instr_bits;

    assign opcode            = id_instr_i[6:0];
    assign rd                = id_instr_i[11:7];
    assign rs1               = id_instr_i[19:15];
    assign rs2               = id_instr_i[24:20];
    assign unused_instr_bits = ^{id_instr_i[31:25], id_instr_i[14:12]};

    // x0 is hard-wired, so it never creates a dependency
    function automatic logic slot_hit(input logic v, input logic [REG_W-1:0] slot_rd,
                                      input logic [REG_W-1:0] r);
        return v && (r != REG_W'(0)) && (slot_rd == r);
    endfunction

    // Operand usage decode from the ID opcode
    always_comb begin
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        rd_written = 1'b0;
        case (opcode)
            7'h37, 7'h17, 7'h6F: rd_written = 1'b1;
            7'h67, 7'h03, 7'h13: begin rs1_used = 1'b1; rd_written = 1'b1; end
            7'h33:               begin rs1_used = 1'b1; rs2_used = 1'b1; rd_written = 1'b1; end
            7'h23, 7'h63:        begin rs1_used = 1'b1; rs2_used = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        hazard = (rs1_used && (slot_hit(ex_v_q, ex_rd_q, rs1) || slot_hit(me_v_q, me_rd_q, rs1)
                                || slot_hit(wb_v_q, wb_rd_q, rs1)))
              || (rs2_used && (slot_hit(ex_v_q, ex_rd_q, rs2) || slot_hit(me_v_q, me_rd_q, rs2)
                                || slot_hit(wb_v_q, wb_rd_q, rs2)));
        freeze = ((state_q == S_RUN) && mem_req_i && !mem_ack_i)
              || ((state_q == S_MEM_WAIT) && !mem_ack_i && (cnt_q < TIMEOUT_C));
    end

    // Pipeline controls in priority order: reset, freeze, branch, hazard
    always_comb begin
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        id_ex_en_o    = 1'b1;
        ex_me_en_o    = 1'b1;
        me_wb_en_o    = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        if (rst_i || freeze) begin
            pc_en_o    = 1'b0;
            if_id_en_o = 1'b0;
            id_ex_en_o = 1'b0;
            ex_me_en_o = 1'b0;
            me_wb_en_o = 1'b0;
        end else if (br_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (hazard) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end
    end

    // Next-state: memory-wait FSM, scoreboard shift, counters
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_err_d   = mem_err_q;
        ex_v_d      = ex_v_q;
        ex_rd_d     = ex_rd_q;
        me_v_d      = me_v_q;
        me_rd_d     = me_rd_q;
        wb_v_d      = wb_v_q;
        wb_rd_d     = wb_rd_q;
        stall_cnt_d = stall_cnt_q + (pc_en_o ? 32'd0 : 32'd1);

        case (state_q)
            S_RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    state_d = S_MEM_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_MEM_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ack_i) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (cnt_q >= TIMEOUT_C) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    mem_err_d = 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase

        if (!freeze) begin
            wb_v_d  = me_v_q;
            wb_rd_d = me_rd_q;
            me_v_d  = ex_v_q;
            me_rd_d = ex_rd_q;
            ex_v_d  = id_ex_flush_o ? 1'b0 : rd_written;
            ex_rd_d = rd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            mem_err_q   <= 1'b0;
            ex_v_q      <= 1'b0;
            ex_rd_q     <= '0;
            me_v_q      <= 1'b0;
            me_rd_q     <= '0;
            wb_v_q      <= 1'b0;
            wb_rd_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_err_q   <= mem_err_d;
            ex_v_q      <= ex_v_d;
            ex_rd_q     <= ex_rd_d;
            me_v_q      <= me_v_d;
            me_rd_q     <= me_rd_d;
            wb_v_q      <= wb_v_d;
            wb_rd_q     <= wb_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err_o   = mem_err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected control words queued at drive time,
// popped and compared mid-cycle; a second instance with MEM_TIMEOUT=4 covers the timeout path.
module tb_pipeline_hazard_ctrl;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] ADDI5   = 32'h0010_0293;
    localparam logic [31:0] ADD6    = 32'h0052_8333;
    localparam logic [31:0] ADDI0   = 32'h0010_0013;
    localparam logic [31:0] ADD6_00 = 32'h0000_0333;
    localparam logic [31:0] LUI5    = 32'h0000_52B7;
    localparam logic [31:0] LUI6    = 32'h0000_0337;
    localparam logic [31:0] LUI7    = 32'h0000_03B7;
    localparam logic [31:0] ADD7    = 32'h0063_03B3;

    // {pc, if_id, id_ex, ex_me, me_wb, if_id_flush, id_ex_flush}
    localparam logic [6:0] RUN_ALL = 7'b11111_00;
    localparam logic [6:0] STALL   = 7'b00111_01;
    localparam logic [6:0] BR      = 7'b11111_11;
    localparam logic [6:0] FRZ     = 7'b00000_00;
    localparam logic [6:0] ZERO    = 7'b00000_00;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_instr;
    logic        br_taken, mem_req, mem_ack;

    logic        pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en, if_id_flush, id_ex_flush, mem_err;
    logic [31:0] stall_cnt;
    logic        pc_en_t, if_id_en_t, id_ex_en_t, ex_me_en_t, me_wb_en_t;
    logic        if_id_flush_t, id_ex_flush_t, mem_err_t;
    logic [31:0] stall_cnt_t;

    int    checks = 0;
    int    errors = 0;
    logic  use_t  = 1'b0;
    string      tag_q[$];
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk_i(clk), .rst_i(rst), .id_instr_i(id_instr), .br_taken_i(br_taken),
        .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en),
        .ex_me_en_o(ex_me_en), .me_wb_en_o(me_wb_en),
        .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
        .mem_err_o(mem_err), .stall_cnt_o(stall_cnt)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut_t (
        .clk_i(clk), .rst_i(rst), .id_instr_i(id_instr), .br_taken_i(br_taken),
        .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_en_o(pc_en_t), .if_id_en_o(if_id_en_t), .id_ex_en_o(id_ex_en_t),
        .ex_me_en_o(ex_me_en_t), .me_wb_en_o(me_wb_en_t),
        .if_id_flush_o(if_id_flush_t), .id_ex_flush_o(id_ex_flush_t),
        .mem_err_o(mem_err_t), .stall_cnt_o(stall_cnt_t)
    );

    function automatic logic [6:0] ctrl_now();
        if (use_t)
            return {pc_en_t, if_id_en_t, id_ex_en_t, ex_me_en_t, me_wb_en_t, if_id_flush_t, id_ex_flush_t};
        return {pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en, if_id_flush, id_ex_flush};
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected controls, compare on the falling edge
    task automatic step(input string tag, input logic [31:0] instr, input logic br,
                        input logic req, input logic ack, input logic [6:0] exp);
        string      t;
        logic [6:0] e;
        logic [6:0] obs;
        id_instr = instr;
        br_taken = br;
        mem_req  = req;
        mem_ack  = ack;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        @(negedge clk);
        t   = tag_q.pop_front();
        e   = exp_q.pop_front();
        obs = ctrl_now();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; id_instr = NOP; br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        step("reset_ctrl", NOP, 0, 1, 0, ZERO);
        chk32("reset_stall_cnt", stall_cnt, 32'd0);
        chk32("reset_mem_err", 32'(mem_err), 32'd0);
        rst = 1'b0;

        // RAW through EX: three bubbles
        step("raw_producer", ADDI5, 0, 0, 0, RUN_ALL);
        step("raw_stall_ex", ADD6, 0, 0, 0, STALL);
        step("raw_stall_me", ADD6, 0, 0, 0, STALL);
        step("raw_stall_wb", ADD6, 0, 0, 0, STALL);
        step("raw_release", ADD6, 0, 0, 0, RUN_ALL);
        chk32("raw_stall_cnt", stall_cnt, 32'd3);
        for (int i = 0; i < 3; i++) step("drain", NOP, 0, 0, 0, RUN_ALL);

        // x0 and non-reading consumers
        step("x0_write", ADDI0, 0, 0, 0, RUN_ALL);
        step("x0_read", ADD6_00, 0, 0, 0, RUN_ALL);
        step("lui_x5", LUI5, 0, 0, 0, RUN_ALL);
        step("lui_x6", LUI6, 0, 0, 0, RUN_ALL);
        for (int i = 0; i < 3; i++) step("drain", NOP, 0, 0, 0, RUN_ALL);
        chk32("nouse_stall_cnt", stall_cnt, 32'd3);

        // Taken branch squashes a stalled consumer
        step("br_producer", ADDI5, 0, 0, 0, RUN_ALL);
        step("br_squash", ADD6, 1, 0, 0, BR);
        step("br_ex_invalid", ADD7, 0, 0, 0, RUN_ALL);
        for (int i = 0; i < 3; i++) step("drain", NOP, 0, 0, 0, RUN_ALL);
        chk32("br_stall_cnt", stall_cnt, 32'd3);

        // Memory wait with ack four cycles after the request
        step("mw_producer", ADDI5, 0, 0, 0, RUN_ALL);
        for (int i = 0; i < 4; i++) step("mw_freeze", NOP, 0, 1, 0, FRZ);
        step("mw_ack", NOP, 0, 1, 1, RUN_ALL);
        chk32("mw_stall_cnt", stall_cnt, 32'd7);
        step("mw_hold_me", ADD6, 0, 0, 0, STALL);
        step("mw_hold_wb", ADD6, 0, 0, 0, STALL);
        step("mw_hold_go", ADD6, 0, 0, 0, RUN_ALL);
        chk32("mw_hold_stall_cnt", stall_cnt, 32'd9);
        for (int i = 0; i < 3; i++) step("drain", NOP, 0, 0, 0, RUN_ALL);
        step("mw_same_ack", NOP, 0, 1, 1, RUN_ALL);
        step("mw_same_ack_after", NOP, 0, 0, 0, RUN_ALL);

        // Freeze beats branch; branch applied on the ack cycle
        step("frz_br", NOP, 1, 1, 0, FRZ);
        step("frz_br_ack", NOP, 1, 0, 1, BR);
        step("frz_br_after", NOP, 0, 0, 0, RUN_ALL);
        chk32("frz_br_stall_cnt", stall_cnt, 32'd10);

        // Reset during MEM_WAIT with a full scoreboard
        step("fill_wb", ADDI5, 0, 0, 0, RUN_ALL);
        step("fill_me", LUI6, 0, 0, 0, RUN_ALL);
        step("fill_ex", LUI7, 0, 0, 0, RUN_ALL);
        step("rst_freeze0", NOP, 0, 1, 0, FRZ);
        step("rst_freeze1", NOP, 0, 1, 0, FRZ);
        chk32("pre_rst_stall_cnt", stall_cnt, 32'd12);
        rst = 1'b1;
        step("rst_mid_ctrl", NOP, 0, 1, 0, ZERO);
        chk32("rst_mid_stall_cnt", stall_cnt, 32'd0);
        chk32("rst_mid_mem_err", 32'(mem_err), 32'd0);
        rst = 1'b0;
        step("post_rst_add", ADD6, 0, 0, 0, RUN_ALL);
        step("post_rst_nop", NOP, 0, 0, 0, RUN_ALL);
        chk32("post_rst_stall_cnt", stall_cnt, 32'd0);

        // Timeout on the MEM_TIMEOUT=4 instance
        use_t = 1'b1;
        for (int i = 0; i < 4; i++) step("to_freeze", NOP, 0, 1, 0, FRZ);
        chk32("to_err_before", 32'(mem_err_t), 32'd0);
        step("to_release", NOP, 0, 1, 0, RUN_ALL);
        chk32("to_err_rise", 32'(mem_err_t), 32'd1);
        chk32("to_stall_cnt", stall_cnt_t, 32'd4);
        step("to_after0", NOP, 0, 0, 0, RUN_ALL);
        step("to_after1", ADDI5, 0, 0, 0, RUN_ALL);
        chk32("to_err_sticky", 32'(mem_err_t), 32'd1);
        rst = 1'b1;
        step("to_rst_ctrl", NOP, 0, 0, 0, ZERO);
        chk32("to_rst_err", 32'(mem_err_t), 32'd0);
        chk32("to_rst_stall_cnt", stall_cnt_t, 32'd0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
